// File: rtl/ctrl_pkg.sv
// Shared state encoding, default opcode map and opcode legality helper for control_sequencer.
package ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEM       = 3'd3,
      WRITEBACK = 3'd4,
      HALTED    = 3'd5,
      TRAP      = 3'd6
   } state_e;

   localparam int DEF_OPCODE_W = 4;
   localparam int DEF_OP_NOP   = 0;
   localparam int DEF_OP_LOAD  = 1;
   localparam int DEF_OP_STORE = 2;
   localparam int DEF_OP_JUMP  = 4;
   localparam int DEF_OP_ALU   = 6;
   localparam int DEF_CNT_W    = 16;

   function automatic logic is_legal_opcode(input logic [31:0] op,
                                            input logic [31:0] op_nop,
                                            input logic [31:0] op_load,
                                            input logic [31:0] op_store,
                                            input logic [31:0] op_jump,
                                            input logic [31:0] op_alu,
                                            input logic [31:0] op_halt);
      return (op == op_nop) || (op == op_load) || (op == op_store) ||
             (op == op_jump) || (op == op_alu) || (op == op_halt);
   endfunction

endpackage

// File: rtl/control_sequencer.sv
// Multi-cycle instruction control sequencer with memory wait states, halt/resume and retire counter.
// Build option CTRL_ILLEGAL_TRAP_EN: undefined opcodes take a one-cycle TRAP instead of halting.
module control_sequencer
   import ctrl_pkg::*;
#(
   parameter int                  OPCODE_W = DEF_OPCODE_W,
   parameter logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(DEF_OP_NOP),
   parameter logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(DEF_OP_LOAD),
   parameter logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(DEF_OP_STORE),
   parameter logic [OPCODE_W-1:0] OP_JUMP  = OPCODE_W'(DEF_OP_JUMP),
   parameter logic [OPCODE_W-1:0] OP_ALU   = OPCODE_W'(DEF_OP_ALU),
   parameter logic [OPCODE_W-1:0] OP_HALT  = '1,
   parameter int                  CNT_W    = DEF_CNT_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                mem_ready,
   input  logic                resume,
   output logic [2:0]          stage,
   output logic                instr_fetch,
   output logic                instr_decode,
   output logic                instr_exec,
   output logic                mem_req,
   output logic                mem_we,
   output logic                write_back,
   output logic                pc_load,
   output logic                retire,
   output logic                halted,
   output logic                illegal,
   output logic [CNT_W-1:0]    instr_count
);

   state_e              state;
   logic [OPCODE_W-1:0] op_reg;
   logic                retire_pend;
   logic                legal;

   assign legal = is_legal_opcode(32'(opcode), 32'(OP_NOP), 32'(OP_LOAD), 32'(OP_STORE),
                                  32'(OP_JUMP), 32'(OP_ALU), 32'(OP_HALT));

   // NOP and STORE finish on a transition that may hinge on live inputs, so their retire is
   // registered and shows in the following FETCH cycle; strobes never see mem_ready directly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= FETCH;
         op_reg      <= '0;
         illegal     <= 1'b0;
         instr_count <= '0;
         retire_pend <= 1'b0;
      end else begin
         retire_pend <= 1'b0;
         if (retire)
            instr_count <= instr_count + CNT_W'(1);
         case (state)
            FETCH: begin
               if (mem_ready)
                  state <= DECODE;
            end
            DECODE: begin
               op_reg <= opcode;
               if (opcode == OP_NOP) begin
                  retire_pend <= 1'b1;
                  state       <= FETCH;
               end else if (opcode == OP_HALT) begin
                  state <= HALTED;
               end else if (legal) begin
                  state <= EXECUTE;
               end else begin
                  illegal <= 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
                  state   <= TRAP;
`else
                  state   <= HALTED;
`endif
               end
            end
            EXECUTE: begin
               if (op_reg == OP_LOAD || op_reg == OP_STORE)
                  state <= MEM;
               else if (op_reg == OP_ALU)
                  state <= WRITEBACK;
               else
                  state <= FETCH;
            end
            MEM: begin
               if (mem_ready) begin
                  if (op_reg == OP_STORE) begin
                     retire_pend <= 1'b1;
                     state       <= FETCH;
                  end else begin
                     state <= WRITEBACK;
                  end
               end
            end
            WRITEBACK: state <= FETCH;
            HALTED: begin
               if (resume) begin
                  illegal <= 1'b0;
                  state   <= FETCH;
               end
            end
            TRAP:    state <= FETCH;
            default: state <= FETCH;
         endcase
      end
   end

   assign stage        = state;
   assign instr_fetch  = (state == FETCH);
   assign instr_decode = (state == DECODE);
   assign instr_exec   = (state == EXECUTE);
   assign mem_req      = (state == FETCH) || (state == MEM);
   assign mem_we       = (state == MEM) && (op_reg == OP_STORE);
   assign write_back   = (state == WRITEBACK);
   assign pc_load      = ((state == EXECUTE) && (op_reg == OP_JUMP)) || (state == TRAP);
   assign retire       = retire_pend || (state == WRITEBACK) ||
                         ((state == EXECUTE) && (op_reg == OP_JUMP));
   assign halted       = (state == HALTED);

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: an instruction-level model queues per-cycle expectations.
module tb_control_sequencer;
   import ctrl_pkg::*;

   localparam int TB_CNT_W = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [3:0]          opcode;
   logic                mem_ready;
   logic                resume;
   logic [2:0]          stage;
   logic                instr_fetch, instr_decode, instr_exec, mem_req, mem_we;
   logic                write_back, pc_load, retire, halted, illegal;
   logic [TB_CNT_W-1:0] instr_count;

   control_sequencer #(.CNT_W(TB_CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready), .resume(resume),
      .stage(stage), .instr_fetch(instr_fetch), .instr_decode(instr_decode),
      .instr_exec(instr_exec), .mem_req(mem_req), .mem_we(mem_we), .write_back(write_back),
      .pc_load(pc_load), .retire(retire), .halted(halted), .illegal(illegal),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]          stage;
      logic [9:0]          strb;
      logic [TB_CNT_W-1:0] cnt;
      int                  cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // Instruction-level model state
   int                  cyc = 0;
   int                  rst_at = -1;
   bit                  aborted;
   logic [3:0]          m_op = '0;
   logic                m_ill = 1'b0;
   logic                m_pend = 1'b0;
   logic [TB_CNT_W-1:0] m_cnt = '0;

   function automatic logic rb();
      return logic'($urandom_range(0, 1));
   endfunction

   function automatic bit op_legal(input logic [3:0] op);
      return op inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd15};
   endfunction

   // strobe vector: fetch decode exec mem_req mem_we wb pc_load retire halted illegal
   task automatic step(input state_e st, input logic mr, input logic [3:0] opc, input logic res);
      exp_t       e;
      logic [9:0] s;
      if (aborted) return;
      @(posedge clk); #1;
      rst_n     = (cyc != rst_at);
      mem_ready = mr;
      opcode    = opc;
      resume    = res;
      s = '0;
      case (st)
         FETCH:     begin s[9] = 1'b1; s[6] = 1'b1; end
         DECODE:    s[8] = 1'b1;
         EXECUTE:   begin s[7] = 1'b1; if (m_op == 4'd4) begin s[3] = 1'b1; s[2] = 1'b1; end end
         MEM:       begin s[6] = 1'b1; s[5] = (m_op == 4'd2); end
         WRITEBACK: begin s[4] = 1'b1; s[2] = 1'b1; end
         HALTED:    s[1] = 1'b1;
         TRAP:      s[3] = 1'b1;
         default:   s = '0;
      endcase
      s[2] = s[2] | m_pend;
      s[0] = m_ill;
      e.stage = st; e.strb = s; e.cnt = m_cnt; e.cyc = cyc;
      q.push_back(e);
      m_pend = 1'b0;
      if (!rst_n) begin
         aborted = 1'b1;
         m_cnt = '0; m_ill = 1'b0; m_op = '0;
      end else if (s[2]) begin
         m_cnt = m_cnt + 1'b1;
      end
      cyc++;
   endtask

   task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input int hw);
      aborted = 1'b0;
      for (int i = 0; i < fw; i++) step(FETCH, 1'b0, 4'($urandom), rb());
      step(FETCH, 1'b1, 4'($urandom), rb());
      step(DECODE, rb(), op, rb());
      if (aborted) return;
      m_op = op;
      if (op == 4'd0) begin
         m_pend = 1'b1;
         return;
      end
      if (op == 4'd15 || !op_legal(op)) begin
         if (!op_legal(op)) m_ill = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
         if (!op_legal(op)) begin
            step(TRAP, rb(), 4'($urandom), rb());
            return;
         end
`endif
         for (int i = 0; i < hw; i++) step(HALTED, rb(), 4'($urandom), 1'b0);
         step(HALTED, rb(), 4'($urandom), 1'b1);
         if (!aborted) m_ill = 1'b0;
         return;
      end
      step(EXECUTE, rb(), 4'($urandom), rb());
      if (op == 4'd4) return;
      if (op == 4'd6) begin
         step(WRITEBACK, rb(), 4'($urandom), rb());
         return;
      end
      for (int i = 0; i < mw; i++) step(MEM, 1'b0, 4'($urandom), rb());
      step(MEM, 1'b1, 4'($urandom), rb());
      if (op == 4'd2) begin
         if (!aborted) m_pend = 1'b1;
         return;
      end
      step(WRITEBACK, rb(), 4'($urandom), rb());
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         logic [9:0] act;
         e = q.pop_front();
         act = {instr_fetch, instr_decode, instr_exec, mem_req, mem_we,
                write_back, pc_load, retire, halted, illegal};
         checks++;
         if (stage !== e.stage) begin
            errors++;
            $display("FAIL stage cyc=%0d actual=%0d required=%0d", e.cyc, stage, e.stage);
         end
         checks++;
         if (act !== e.strb) begin
            errors++;
            $display("FAIL strobes cyc=%0d actual=%b required=%b", e.cyc, act, e.strb);
         end
         checks++;
         if (instr_count !== e.cnt) begin
            errors++;
            $display("FAIL instr_count cyc=%0d actual=%0d required=%0d", e.cyc, instr_count, e.cnt);
         end
      end
   end

   initial begin
      int r;
      logic [3:0] op;
      rst_n = 1'b0; opcode = '0; mem_ready = 1'b0; resume = 1'b0;
      repeat (3) @(posedge clk);

      run_instr(4'd6, 0, 0, 0);
      run_instr(4'd1, 0, 3, 0);
      run_instr(4'd2, 0, 0, 0);
      run_instr(4'd4, 1, 0, 0);
      run_instr(4'd15, 0, 0, 4);
      run_instr(4'd3, 0, 0, 2);
      for (int i = 0; i < 5; i++) run_instr(4'd0, 0, 0, 0);
      rst_at = cyc + 4;
      run_instr(4'd1, 0, 3, 0);
      rst_at = -1;
      run_instr(4'd0, 0, 0, 0);

      for (int n = 0; n < 250; n++) begin
         r = $urandom_range(0, 9);
         case (r)
            0, 1:    op = 4'd0;
            2:       op = 4'd1;
            3:       op = 4'd2;
            4:       op = 4'd4;
            5, 6:    op = 4'd6;
            7:       op = 4'd15;
            default: op = ($urandom_range(0, 3) == 0) ? 4'd3 : 4'($urandom_range(7, 14));
         endcase
         if (n == 120) rst_at = cyc + $urandom_range(0, 2);
         run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4));
         rst_at = -1;
      end

      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
